// File: rtl/pwm_period_calc.sv
// Turns a PWM frequency (Hz) and a duty cycle (%) into the period and high-time clock counts.
// Uses serial restoring dividers and a shift-add multiplier. Both outputs are updated together.
//
// state | meaning
// IDLE  | compare clamped inputs with the last captured pair; start when they differ or pending
// DIV_P | P = SYSCLK_FRQ / f, one quotient bit per cycle, MSB first
// MUL_D | product = P * d, shift-add, one multiplier bit per cycle
// DIV_H | H = product / 100, one quotient bit per cycle, MSB first
// DONE  | load period_cycles/high_cycles together and pulse params_valid
module pwm_period_calc #(
    parameter int SYSCLK_FRQ = 50000000,
    parameter int FREQ_MAX   = 10000,
    parameter int FREQ_MIN   = 1,
    parameter int PERIOD_W   = 26
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic [13:0]         freq_Hz,
    input  logic [6:0]          duty_cycle,
    output logic [PERIOD_W-1:0] period_cycles,
    output logic [PERIOD_W-1:0] high_cycles,
    output logic                params_valid,
    output logic                busy
);

    localparam int FREQ_W  = 14;
    localparam int DUTY_W  = 7;
    localparam int PROD_W  = PERIOD_W + DUTY_W;
    localparam int CNT_W   = $clog2(PROD_W + 1);
    localparam int REM_H_W = 7;
    localparam int FMIN_SAFE = (FREQ_MIN == 0) ? 1 : FREQ_MIN;

    localparam logic [FREQ_W-1:0]   F_MIN_V    = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0]   F_MAX_V    = FREQ_W'(FREQ_MAX);
    localparam logic [DUTY_W-1:0]   D_MAX_V    = DUTY_W'(100);
    localparam logic [REM_H_W:0]    PCT_DIV    = 8'd100;
    localparam logic [PERIOD_W-1:0] SYSCLK_V   = PERIOD_W'(SYSCLK_FRQ);
    localparam logic [PERIOD_W-1:0] PERIOD_RST = PERIOD_W'(SYSCLK_FRQ / FMIN_SAFE);
    localparam logic [CNT_W-1:0]    CNT_DIV_P  = CNT_W'(PERIOD_W - 1);
    localparam logic [CNT_W-1:0]    CNT_MUL_D  = CNT_W'(DUTY_W - 1);
    localparam logic [CNT_W-1:0]    CNT_DIV_H  = CNT_W'(PROD_W - 1);

    if (FREQ_MIN == 0) begin : g_chk_fmin
        $error("pwm_period_calc: FREQ_MIN must be nonzero (it is the divisor floor)");
    end
    if (FREQ_MIN > FREQ_MAX) begin : g_chk_frange
        $error("pwm_period_calc: FREQ_MIN must not exceed FREQ_MAX");
    end
    if (longint'(SYSCLK_FRQ / FMIN_SAFE) >= (longint'(1) << PERIOD_W)) begin : g_chk_width
        $error("pwm_period_calc: PERIOD_W too narrow for SYSCLK_FRQ / FREQ_MIN");
    end

    typedef enum logic [2:0] {
        IDLE,
        DIV_P,
        MUL_D,
        DIV_H,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0]    cnt;
    logic [FREQ_W-1:0]   f_cap;
    logic [DUTY_W-1:0]   d_cap;
    logic                pending;
    logic [PERIOD_W-1:0] quo_p;
    logic [FREQ_W-1:0]   rem_p;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   mcand;
    logic [DUTY_W-1:0]   mplier;
    logic [REM_H_W-1:0]  rem_h;

    logic [FREQ_W-1:0]   f_clamp;
    logic [DUTY_W-1:0]   d_clamp;
    logic                start;
    logic [FREQ_W:0]     p_rem_sh;
    logic                p_ge;
    logic [FREQ_W-1:0]   p_rem_nx;
    logic [PROD_W-1:0]   prod_sum;
    logic [REM_H_W:0]    h_rem_sh;
    logic                h_ge;
    logic [REM_H_W-1:0]  h_rem_nx;
    logic                cnt_tc;

    always_comb begin
        f_clamp = freq_Hz;
        if (freq_Hz < F_MIN_V) begin
            f_clamp = F_MIN_V;
        end else if (freq_Hz > F_MAX_V) begin
            f_clamp = F_MAX_V;
        end
        d_clamp = (duty_cycle > D_MAX_V) ? D_MAX_V : duty_cycle;
        start   = pending || (f_clamp != f_cap) || (d_clamp != d_cap);
    end

    // One restoring-division step per datapath; the dividend shifts out of the quotient register.
    always_comb begin
        p_rem_sh = {rem_p, quo_p[PERIOD_W-1]};
        p_ge     = (p_rem_sh >= {1'b0, f_cap});
        p_rem_nx = p_ge ? FREQ_W'(p_rem_sh - {1'b0, f_cap}) : p_rem_sh[FREQ_W-1:0];

        prod_sum = prod + (mplier[0] ? mcand : '0);

        h_rem_sh = {rem_h, prod[PROD_W-1]};
        h_ge     = (h_rem_sh >= PCT_DIV);
        h_rem_nx = h_ge ? REM_H_W'(h_rem_sh - PCT_DIV) : h_rem_sh[REM_H_W-1:0];

        cnt_tc   = (cnt == '0);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = DIV_P;
            end
            DIV_P:   if (cnt_tc) state_nx = MUL_D;
            MUL_D:   if (cnt_tc) state_nx = DIV_H;
            DIV_H:   if (cnt_tc) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                busy     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cnt           <= '0;
            f_cap         <= F_MIN_V;
            d_cap         <= '0;
            pending       <= 1'b1;
            quo_p         <= '0;
            rem_p         <= '0;
            prod          <= '0;
            mcand         <= '0;
            mplier        <= '0;
            rem_h         <= '0;
            period_cycles <= PERIOD_RST;
            high_cycles   <= '0;
            params_valid  <= 1'b0;
        end else begin
            params_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        f_cap   <= f_clamp;
                        d_cap   <= d_clamp;
                        pending <= 1'b0;
                        quo_p   <= SYSCLK_V;
                        rem_p   <= '0;
                        cnt     <= CNT_DIV_P;
                    end
                end
                DIV_P: begin
                    quo_p <= {quo_p[PERIOD_W-2:0], p_ge};
                    rem_p <= p_rem_nx;
                    cnt   <= cnt - 1'b1;
                    if (cnt_tc) begin
                        // The last quotient bit lands this edge, so feed the multiplier the same value.
                        mcand  <= {{DUTY_W{1'b0}}, quo_p[PERIOD_W-2:0], p_ge};
                        mplier <= d_cap;
                        prod   <= '0;
                        cnt    <= CNT_MUL_D;
                    end
                end
                MUL_D: begin
                    prod   <= prod_sum;
                    mcand  <= {mcand[PROD_W-2:0], 1'b0};
                    mplier <= {1'b0, mplier[DUTY_W-1:1]};
                    cnt    <= cnt - 1'b1;
                    if (cnt_tc) begin
                        rem_h <= '0;
                        cnt   <= CNT_DIV_H;
                    end
                end
                DIV_H: begin
                    prod  <= {prod[PROD_W-2:0], h_ge};
                    rem_h <= h_rem_nx;
                    cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    period_cycles <= quo_p;
                    high_cycles   <= prod[PERIOD_W-1:0];
                    params_valid  <= 1'b1;
                end
                default: begin
                    pending <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_period_calc.sv
// Scoreboard bench for pwm_period_calc: expected (period, high) pairs are queued at stimulus time
// and a negedge monitor pops one on every params_valid pulse.
module tb_pwm_period_calc;

    localparam longint SYSCLK = 50000000;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic [13:0] freq_Hz;
    logic [6:0]  duty_cycle;
    logic [25:0] period_cycles;
    logic [25:0] high_cycles;
    logic        params_valid;
    logic        busy;

    typedef struct {
        longint p;
        longint h;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_fc;
    int   last_dc;
    logic [25:0] prev_p;
    logic [25:0] prev_h;

    pwm_period_calc dut (
        .iCLK         (iCLK),
        .iRST_n       (iRST_n),
        .freq_Hz      (freq_Hz),
        .duty_cycle   (duty_cycle),
        .period_cycles(period_cycles),
        .high_cycles  (high_cycles),
        .params_valid (params_valid),
        .busy         (busy)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #900000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic int clamp_f(int f);
        return (f < 1) ? 1 : ((f > 10000) ? 10000 : f);
    endfunction

    function automatic int clamp_d(int d);
        return (d > 100) ? 100 : d;
    endfunction

    function automatic exp_t model(int f, int d);
        exp_t e;
        e.p = SYSCLK / clamp_f(f);
        e.h = (e.p * clamp_d(d)) / 100;
        return e;
    endfunction

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops on params_valid; outputs must hold at every other cycle.
    always @(negedge iCLK) begin
        exp_t e;
        if (iRST_n) begin
            if (params_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid period=%0d high=%0d required=no pulse",
                             period_cycles, high_cycles);
                end else begin
                    e = sb.pop_front();
                    chk("sb_period", longint'(period_cycles), e.p);
                    chk("sb_high", longint'(high_cycles), e.h);
                end
                chk("high_le_period", longint'(high_cycles <= period_cycles), 1);
            end else begin
                chk("hold_period", longint'(period_cycles), longint'(prev_p));
                chk("hold_high", longint'(high_cycles), longint'(prev_h));
            end
        end
        prev_p = period_cycles;
        prev_h = high_cycles;
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge iCLK);
            lat++;
        end while (!params_valid && lat < 400);
        if (!params_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_timeout actual=no pulse in %0d cycles required=pulse", lat);
        end
    endtask

    task automatic count_pulses(int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge iCLK);
            if (params_valid) cnt++;
        end
    endtask

    task automatic run_req(int f, int d);
        int lat;
        int n;
        int fc;
        int dc;
        fc = clamp_f(f);
        dc = clamp_d(d);
        @(negedge iCLK);
        freq_Hz    = 14'(f);
        duty_cycle = 7'(d);
        if (fc != last_fc || dc != last_dc) begin
            sb.push_back(model(f, d));
            last_fc = fc;
            last_dc = dc;
            wait_valid(lat);
            chk("latency", lat, 68);
            @(negedge iCLK);
            chk("valid_one_cycle", longint'(params_valid), 0);
            chk("idle_after_done", longint'(busy), 0);
        end else begin
            count_pulses(80, n);
            chk("no_retrigger", n, 0);
        end
    endtask

    initial begin
        int lat;
        int n;
        iRST_n     = 1'b0;
        freq_Hz    = 14'd1000;
        duty_cycle = 7'd50;
        repeat (3) @(negedge iCLK);
        chk("rst_period", longint'(period_cycles), 50000000);
        chk("rst_high", longint'(high_cycles), 0);
        chk("rst_valid", longint'(params_valid), 0);
        chk("rst_busy", longint'(busy), 0);

        sb.push_back(model(1000, 50));
        last_fc = 1000;
        last_dc = 50;
        iRST_n  = 1'b1;
        wait_valid(lat);
        chk("latency_after_reset", lat, 68);
        count_pulses(100, n);
        chk("single_valid_after_reset", n, 0);

        run_req(3, 33);
        run_req(0, 127);
        run_req(16383, 0);
        run_req(12000, 0);
        run_req(10000, 0);

        // Duty change in the middle of a computation: finish old pair, then redo automatically.
        @(negedge iCLK);
        freq_Hz    = 14'd1000;
        duty_cycle = 7'd50;
        sb.push_back(model(1000, 50));
        repeat (20) @(negedge iCLK);
        chk("busy_mid_compute", longint'(busy), 1);
        duty_cycle = 7'd75;
        sb.push_back(model(1000, 75));
        wait_valid(lat);
        chk("latency_first_of_two", lat, 48);
        wait_valid(lat);
        chk("latency_second_of_two", lat, 68);
        last_fc = 1000;
        last_dc = 75;
        count_pulses(100, n);
        chk("no_third_valid", n, 0);

        // Reset while dividing by 100: outputs snap back, then a fresh run with current inputs.
        @(negedge iCLK);
        freq_Hz    = 14'd2000;
        duty_cycle = 7'd40;
        sb.push_back(model(2000, 40));
        repeat (50) @(negedge iCLK);
        chk("busy_in_div_h", longint'(busy), 1);
        iRST_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_period", longint'(period_cycles), 50000000);
        chk("abort_high", longint'(high_cycles), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_valid", longint'(params_valid), 0);
        repeat (2) @(negedge iCLK);
        sb.push_back(model(2000, 40));
        last_fc = 2000;
        last_dc = 40;
        iRST_n  = 1'b1;
        wait_valid(lat);
        chk("latency_after_abort", lat, 68);
        count_pulses(100, n);
        chk("single_valid_after_abort", n, 0);

        for (int i = 0; i < 40; i++) begin
            int f;
            int d;
            case ($urandom_range(0, 3))
                0:       f = int'($urandom_range(0, 20));
                1:       f = int'($urandom_range(9990, 10010));
                2:       f = last_fc;
                default: f = int'($urandom_range(0, 16383));
            endcase
            d = ($urandom_range(0, 4) == 0) ? last_dc : int'($urandom_range(0, 127));
            run_req(f, d);
        end

        repeat (5) @(negedge iCLK);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
